// File: rtl/output_collector.sv
// output_collector
//
// Last stage after the convolution controller/datapath. Each finished pixel
// (accumulator plus (x, y, ch) tag) is requantised by an arithmetic right
// shift with saturation. It is then buffered in a small first-word-fall-through
// FIFO and drained to the host over a valid/ready handshake.
//
// Ports:
//   clk, arst_n_in         clock (rising edge), asynchronous active-low reset
//   start                  one-cycle pulse: empties FIFO, clears count/flags
//   in_valid               result strobe from the controller (output_valid)
//   in_data                signed accumulator, ACC_WIDTH bits
//   in_x, in_y, in_ch      32-bit result tag
//   out_valid, out_ready   host handshake for the FIFO head
//   out_data               requantised head value, OUT_WIDTH bits
//   out_x, out_y, out_ch   head tag
//   stall                  FIFO almost full (occupancy >= FIFO_DEPTH-1)
//   overflow               sticky: a result arrived while full and was dropped
//   done                   TOTAL_OUTPUTS results delivered this run
//   out_count              results delivered to the host this run
module output_collector #(
  parameter int ACC_WIDTH     = 32,
  parameter int OUT_WIDTH     = 16,
  parameter int SHIFT         = 8,
  parameter int FIFO_DEPTH    = 4,
  parameter int TOTAL_OUTPUTS = 1024*1024*64
) (
  input  logic                 clk,
  input  logic                 arst_n_in,
  input  logic                 start,
  input  logic                 in_valid,
  input  logic [ACC_WIDTH-1:0] in_data,
  input  logic [31:0]          in_x,
  input  logic [31:0]          in_y,
  input  logic [31:0]          in_ch,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic [31:0]          out_x,
  output logic [31:0]          out_y,
  output logic [31:0]          out_ch,
  output logic                 stall,
  output logic                 overflow,
  output logic                 done,
  output logic [31:0]          out_count
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int WORD_W = OUT_WIDTH + 96;

  // Saturation bounds expressed at accumulator width so the compare is signed.
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;
  localparam logic [31:0] TOTAL_C = 32'(TOTAL_OUTPUTS);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ACTIVE     = 2'd1,
    DRAIN_DONE = 2'd2
  } state_t;

  // Arithmetic right shift followed by clamp to the signed OUT_WIDTH range.
  function automatic logic [OUT_WIDTH-1:0] requant(input logic signed [ACC_WIDTH-1:0] acc);
    logic signed [ACC_WIDTH-1:0] s;
    s = acc >>> SHIFT;
    if (s > SAT_MAX) begin
      requant = SAT_MAX[OUT_WIDTH-1:0];
    end else if (s < SAT_MIN) begin
      requant = SAT_MIN[OUT_WIDTH-1:0];
    end else begin
      requant = s[OUT_WIDTH-1:0];
    end
  endfunction

  logic [WORD_W-1:0] mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  occ_r;
  logic [CNT_W-1:0]  occ_next_s;
  logic [31:0]       count_r;
  logic              stall_r;
  logic              overflow_r;
  logic              done_r;
  state_t            state_r;
  state_t            state_s;
  logic              full_s;
  logic              push_s;
  logic              pop_s;
  logic              drop_s;
  logic              final_pop_s;
  logic [WORD_W-1:0] head_s;

  // start overrides any push or pop in the same cycle.
  assign full_s      = (occ_r == CNT_W'(FIFO_DEPTH));
  assign out_valid   = (occ_r != {CNT_W{1'b0}});
  assign pop_s       = out_valid && out_ready && !start;
  assign push_s      = in_valid && (!full_s || pop_s) && !start;
  assign drop_s      = in_valid && full_s && !pop_s && !start;
  assign final_pop_s = pop_s && ((count_r + 32'd1) == TOTAL_C);

  // Head is read straight from storage so it appears the cycle after the push.
  assign head_s    = mem_r[rd_ptr_r];
  assign out_data  = head_s[WORD_W-1 -: OUT_WIDTH];
  assign out_x     = head_s[95:64];
  assign out_y     = head_s[63:32];
  assign out_ch    = head_s[31:0];
  assign stall     = stall_r;
  assign overflow  = overflow_r;
  assign done      = done_r;
  assign out_count = count_r;

  // Next occupancy: a simultaneous push and pop leave it unchanged.
  always_comb begin
    occ_next_s = occ_r;
    if (start) begin
      occ_next_s = {CNT_W{1'b0}};
    end else if (push_s && !pop_s) begin
      occ_next_s = occ_r + CNT_W'(1);
    end else if (pop_s && !push_s) begin
      occ_next_s = occ_r - CNT_W'(1);
    end else begin
      occ_next_s = occ_r;
    end
  end

  // FIFO storage, pointers and occupancy.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= {WORD_W{1'b0}};
      end
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      occ_r    <= {CNT_W{1'b0}};
    end else if (start) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      occ_r    <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= {requant($signed(in_data)), in_x, in_y, in_ch};
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      occ_r <= occ_next_s;
    end
  end

  // Status registers: almost-full, sticky overflow, delivered count, done.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      stall_r    <= 1'b0;
      overflow_r <= 1'b0;
      count_r    <= 32'd0;
      done_r     <= 1'b0;
    end else if (start) begin
      stall_r    <= 1'b0;
      overflow_r <= 1'b0;
      count_r    <= 32'd0;
      done_r     <= 1'b0;
    end else begin
      stall_r <= (occ_next_s >= CNT_W'(FIFO_DEPTH - 1));
      if (drop_s) begin
        overflow_r <= 1'b1;
      end
      if (pop_s) begin
        count_r <= count_r + 32'd1;
      end
      if (final_pop_s && (state_r == ACTIVE)) begin
        done_r <= 1'b1;
      end
    end
  end

  // Run state register.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Run state transitions; the state only gates when done may be raised.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = ACTIVE;
        end else begin
          state_s = IDLE;
        end
      end
      ACTIVE: begin
        if (start) begin
          state_s = ACTIVE;
        end else if (final_pop_s) begin
          state_s = DRAIN_DONE;
        end else begin
          state_s = ACTIVE;
        end
      end
      DRAIN_DONE: begin
        if (start) begin
          state_s = ACTIVE;
        end else begin
          state_s = DRAIN_DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_output_collector.sv
module tb_output_collector;

  logic        clk;
  logic        arst_n_in;
  logic        start;
  logic        in_valid;
  logic [31:0] in_data;
  logic [31:0] in_x, in_y, in_ch;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [31:0] out_x, out_y, out_ch;
  logic        stall;
  logic        overflow;
  logic        done;
  logic [31:0] out_count;

  int checks;
  int errors;
  int run_pops;
  logic [111:0] sb[$];

  output_collector #(
    .ACC_WIDTH(32), .OUT_WIDTH(16), .SHIFT(8), .FIFO_DEPTH(4), .TOTAL_OUTPUTS(6)
  ) dut (
    .clk(clk), .arst_n_in(arst_n_in), .start(start),
    .in_valid(in_valid), .in_data(in_data),
    .in_x(in_x), .in_y(in_y), .in_ch(in_ch),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_x(out_x), .out_y(out_y), .out_ch(out_ch),
    .stall(stall), .overflow(overflow), .done(done), .out_count(out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: a pop happens at the next rising edge whenever valid and ready
  // are both high mid-cycle; compare the presented head with the queue front.
  always @(negedge clk) begin
    if (arst_n_in && out_valid && out_ready && !start) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pop: got 0x%0h expected none", {out_data, out_x, out_y, out_ch});
      end else begin
        logic [111:0] e;
        e = sb.pop_front();
        if ({out_data, out_x, out_y, out_ch} !== e) begin
          errors++;
          $display("FAIL head_word: got 0x%0h expected 0x%0h",
                   {out_data, out_x, out_y, out_ch}, e);
        end
      end
      run_pops++;
    end
  end

  // Bench-side acceptance model: FIFO occupancy equals the outstanding queue.
  function automatic bit can_accept();
    return (sb.size() < 4) || (out_ready && (sb.size() > 0));
  endfunction

  // Drive inputs for one cycle (called at posedge+1); exp is hand-computed.
  task automatic drive(input logic [31:0] d, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] c, input logic [15:0] e);
    in_valid = 1'b1; in_data = d; in_x = x; in_y = y; in_ch = c;
    if (can_accept()) sb.push_back({e, x, y, c});
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic do_start();
    out_ready = 1'b0;
    start = 1'b1;
    sb.delete();
    run_pops = 0;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic drain(input string name);
    out_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (sb.size() == 0) break;
      @(posedge clk); #1;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: got %0d left expected 0", name, sb.size());
    end
    out_ready = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0; run_pops = 0;
    arst_n_in = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 32'd0;
    in_x = 32'd0; in_y = 32'd0; in_ch = 32'd0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 16'd0);
    chk("rst_out_x", out_x, 32'd0);
    chk("rst_stall", stall, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_out_count", out_count, 32'd0);
    arst_n_in = 1'b1;
    @(posedge clk); #1;

    // Single result
    do_start();
    drive(32'h0000_1234, 32'd3, 32'd5, 32'd7, 16'h0012);
    chk("single_valid", out_valid, 1'b1);
    chk("single_data", out_data, 16'h0012);
    chk("single_tag", {out_x, out_y, out_ch}, {32'd3, 32'd5, 32'd7});
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("single_count", out_count, 32'd1);
    chk("single_empty", out_valid, 1'b0);

    // Saturation
    drive(32'h7FFF_FFFF, 32'd1, 32'd0, 32'd0, 16'h7FFF);
    drive(32'h8000_0000, 32'd2, 32'd0, 32'd0, 16'h8000);
    drive(32'hFFFF_FF00, 32'd3, 32'd0, 32'd0, 16'hFFFF);
    drain("sat");

    // Fill and overflow
    do_start();
    drive(32'h0000_0100, 32'd10, 32'd0, 32'd0, 16'd1);
    drive(32'h0000_0200, 32'd11, 32'd0, 32'd0, 16'd2);
    chk("fill_stall_2", stall, 1'b0);
    drive(32'h0000_0300, 32'd12, 32'd0, 32'd0, 16'd3);
    chk("fill_stall_3", stall, 1'b1);
    drive(32'h0000_0400, 32'd13, 32'd0, 32'd0, 16'd4);
    chk("fill_no_ovf_4", overflow, 1'b0);
    drive(32'h0000_0500, 32'd14, 32'd0, 32'd0, 16'd5);
    chk("fill_overflow", overflow, 1'b1);
    chk("fill_queued", sb.size(), 4);
    drain("fill");
    chk("fill_count", out_count, 32'd4);
    chk("fill_ovf_sticky", overflow, 1'b1);

    // Full with simultaneous push/pop, wrapping the pointers
    do_start();
    chk("start_clr_ovf", overflow, 1'b0);
    for (int k = 0; k < 4; k++)
      drive(32'((k + 1) * 256), 32'(20 + k), 32'd1, 32'd2, 16'(k + 1));
    out_ready = 1'b1;
    for (int k = 4; k < 14; k++) begin
      drive(32'((k + 1) * 256), 32'(20 + k), 32'd1, 32'd2, 16'(k + 1));
      chk("pp_stall_full", stall, 1'b1);
    end
    chk("pp_no_overflow", overflow, 1'b0);
    chk("pp_count", out_count, 32'd10);
    drain("pp");

    // Completion with random backpressure
    do_start();
    begin
      int pushed;
      int cyc;
      pushed = 0;
      cyc = 0;
      while (run_pops < 6 && cyc < 300) begin
        chk("cmp_done_low", done, 1'b0);
        out_ready = 1'($urandom_range(0, 1));
        if (pushed < 6 && can_accept()) begin
          in_valid = 1'b1; in_data = 32'((pushed + 1) * 256);
          in_x = 32'(pushed); in_y = 32'(pushed); in_ch = 32'(pushed);
          sb.push_back({16'(pushed + 1), in_x, in_y, in_ch});
          pushed++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc++;
      end
      out_ready = 1'b0;
      chk("cmp_pops", run_pops, 6);
      chk("cmp_done", done, 1'b1);
      chk("cmp_count", out_count, 32'd6);
    end
    do_start();
    chk("cmp_clr_done", done, 1'b0);
    chk("cmp_clr_count", out_count, 32'd0);
    chk("cmp_clr_valid", out_valid, 1'b0);

    // Reset mid-run
    for (int k = 0; k < 4; k++)
      drive(32'((k + 1) * 256), 32'(40 + k), 32'd0, 32'd0, 16'(k + 1));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("mid_count_pre", out_count, 32'd1);
    #3;
    arst_n_in = 1'b0;
    #1;
    chk("mid_valid", out_valid, 1'b0);
    chk("mid_count", out_count, 32'd0);
    chk("mid_overflow", overflow, 1'b0);
    chk("mid_data", out_data, 16'd0);
    sb.delete();
    run_pops = 0;
    #3;
    arst_n_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_no_stale", out_valid, 1'b0);
    drive(32'h0000_0900, 32'd9, 32'd8, 32'd7, 16'h0009);
    drain("post_rst");
    chk("post_rst_count", out_count, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
